// File: rtl/sub_result_formatter.sv
// Formats 4-bit subtractor results (res/cout) into sign, BCD tens/units and a zero flag,
// buffers them in a small FIFO with valid/ready on both sides, and keeps saturating counts.
module sub_result_formatter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_res,
    input  logic             in_cout,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_sign,
    output logic             out_tens,
    output logic [3:0]       out_units,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] neg_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Word layout {zero, sign, tens, units}; a borrowed res=0 gives magnitude 16 (tens=1, units=6).
    function automatic logic [6:0] fmt_word(input logic [3:0] res, input logic cout);
        logic signed [5:0] diff;
        logic [4:0]        mag;
        logic              tens;
        logic [3:0]        units;
        diff  = cout ? $signed({2'b00, res}) : ($signed({2'b00, res}) - 6'sd16);
        mag   = (diff < 0) ? 5'(-diff) : 5'(diff);
        tens  = (mag >= 5'd10);
        units = tens ? 4'(mag - 5'd10) : mag[3:0];
        return {cout && (res == 4'd0), ~cout, tens, units};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [6:0]    word_p0;
    logic          vld_p0;
    logic          pop;
    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [6:0]    last_q;
    logic [6:0]    head;

    // Stage p0: combinational conversion feeding the FIFO write port
    assign word_p0  = fmt_word(in_res, in_cout);
    assign in_ready = (occ != (AW+1)'(DEPTH));
    assign vld_p0   = in_valid && in_ready;
    assign out_valid = (occ != '0);
    assign pop      = out_valid && out_ready;

    // FIFO storage: data only, occupancy decides what is meaningful
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem[wr_ptr] <= word_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            last_q    <= '0;
            neg_cnt   <= '0;
            total_cnt <= '0;
        end else begin
            if (vld_p0) begin
                wr_ptr    <= wr_ptr + AW'(1);
                total_cnt <= sat_inc(total_cnt);
                if (word_p0[5]) begin
                    neg_cnt <= sat_inc(neg_cnt);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({vld_p0, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Output stage: head entry when valid, otherwise the last entry popped
    assign head      = out_valid ? mem[rd_ptr] : last_q;
    assign out_zero  = head[6];
    assign out_sign  = head[5];
    assign out_tens  = head[4];
    assign out_units = head[3:0];

endmodule

// File: doc/sub_result_formatter.md
Name: sub_result_formatter

Overview:
Downstream consumer of the 4-bit 2's-complement subtractor (res/cout). Converts each raw difference word into sign + magnitude and then into BCD digits (tens, units). Results are buffered in a small FIFO with valid/ready handshakes on both sides, and running statistics counters are kept. Output feeds the display/readout stage.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
CNT_W, 8, width of statistics counters (saturating)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_res  input  4  subtractor result word (A-B mod 16)
in_cout  input  1  subtractor carry-out; 1 = no borrow (A>=B), 0 = borrow (A<B)
in_valid  input  1  in_res/in_cout valid this cycle
in_ready  output  1  formatter can accept a word
out_sign  output  1  1 = negative difference
out_tens  output  1  BCD tens digit of magnitude (0 or 1)
out_units  output  4  BCD units digit of magnitude (0..9)
out_zero  output  1  difference is exactly 0
out_valid  output  1  out_* fields hold a valid FIFO head entry
out_ready  input  1  downstream accepts head entry
neg_cnt  output  CNT_W  number of accepted negative results
total_cnt  output  CNT_W  number of accepted results

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, pointers/occupancy 0; out_valid=0; out_sign/out_tens/out_units/out_zero=0; neg_cnt=total_cnt=0; in_ready=1 from the first clock edge after release. Reset mid-operation discards all buffered entries immediately and is not a handshake event.
- Accept: word accepted on a rising edge when in_valid && in_ready. in_ready = !full (registered occupancy); no write-through when full, even if a read happens in the same cycle.
- Conversion (combinational, ahead of the FIFO write):
  - sign = ~in_cout
  - mag (5 bit) = in_cout ? {1'b0,in_res} : 16 - in_res
  - in_res=0 with in_cout=0 yields mag=16 (not produced by a valid subtractor; carried through, not flagged)
  - zero = in_cout && (in_res==0)
  - tens = (mag>=10); units = mag - 10*tens; mag=16 -> tens=1, units=6
- FIFO word = {zero, sign, tens, units}, 7 bits. Order is strict FIFO.
- Output: out_* reflect the FIFO head; out_valid = !empty. Head is popped on a rising edge when out_valid && out_ready. When out_valid=0, out_* hold their last value (0 after reset).
- Latency: a word accepted at edge N is visible with out_valid=1 after edge N (1 cycle) when the FIFO was empty.
- Simultaneous push and pop, with FIFO neither empty nor full: occupancy unchanged; both succeed.
- Push while empty with out_ready=1: no bypass. The entry appears the next cycle.
- Pointers wrap modulo DEPTH. Full = occupancy==DEPTH; empty = occupancy==0.
- Counters: on each accepted word, total_cnt increments, and neg_cnt increments if sign=1. Both saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset, then push (res=1111, cout=0) [A=1000,B=1001] -> next cycle out_valid=1, sign=1, tens=0, units=1, zero=0; neg_cnt=1, total_cnt=1.
- Push (1001,1) [1100-0011], then (1001,0) [1000-1111], then (0110,1) [1111-1001], with out_ready=1 -> outputs in order: +0/9, -0/7, +0/6.
- Push (0000,1) [A=B=1111] -> sign=0, zero=1, tens=0, units=0. Push (0000,0) -> sign=1, tens=1, units=6, zero=0.
- Hold out_ready=0 and push 5 words with DEPTH=4 -> in_ready drops after the 4th accept; the 5th is held. Raise out_ready -> the 5th is accepted the cycle after the first pop, and order is preserved.
- FIFO at 2 entries with push+pop in the same cycle for 10 cycles -> occupancy stays 2 and no word is lost or duplicated. Pointer wrap is exercised.
- Assert rst_n=0 asynchronously mid-stream with 3 entries held -> out_valid and counters go to 0 immediately, without a clock. Push 300 negative words with CNT_W=8 -> neg_cnt=total_cnt=255.
